scan_ctrl: RTL and testbench

SCAN_CTRL -- requirements
Module: scan_ctrl

---
 rtl/scan_pkg.sv | 27 ++
 rtl/scan_byte_serdes.sv | 50 +++++
 rtl/scan_ctrl.sv | 160 ++++++++++++++++
 tb/tb_scan_ctrl.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared constants and types for the scan controller.
// Holds command encodings, FSM states, DUT reset length and default chain length.
`timescale 1ns/1ps
package scan_pkg;

  localparam int NREGS_DEF = 1919;
  localparam int DRST_LEN  = 4;
  localparam int BYTE_W    = 8;

  localparam logic [1:0] OP_SHIFT = 2'd0;
  localparam logic [1:0] OP_RUN   = 2'd1;
  localparam logic [1:0] OP_DRST  = 2'd2;
  localparam logic [1:0] OP_NOP   = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LO,
    S_HI,
    S_PUSH,
    S_RUN_LO,
    S_RUN_HI,
    S_DRST,
    S_DONE
  } state_e;

endpackage

// File: rtl/scan_byte_serdes.sv
// Byte serialiser/deserialiser for the scan chain.
// Ports: ld_i loads an in-byte, adv_i shifts it out LSB-first on si_o,
// smp_i captures so_i at the current bit index, clr_i empties the out-byte.
`timescale 1ns/1ps
module scan_byte_serdes
  import scan_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              ld_i,
  input  logic [BYTE_W-1:0] din_i,
  input  logic              adv_i,
  input  logic              smp_i,
  input  logic              clr_i,
  input  logic              so_i,
  output logic              si_o,
  output logic [BYTE_W-1:0] byte_o,
  output logic              last_o
);

  logic [BYTE_W-1:0] in_sr;
  logic [BYTE_W-1:0] out_sr;
  logic [2:0]        idx;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_sr  <= '0;
      out_sr <= '0;
      idx    <= '0;
    end else begin
      if (ld_i) begin
        in_sr <= din_i;
        idx   <= '0;
      end else if (adv_i) begin
        in_sr <= {1'b0, in_sr[BYTE_W-1:1]};
        idx   <= idx + 3'd1;
      end
      // bits land at their own position so a short last byte keeps zero MSBs
      if (clr_i)
        out_sr <= '0;
      else if (smp_i)
        out_sr[idx] <= so_i;
    end
  end

  assign si_o   = in_sr[0];
  assign byte_o = out_sr;
  assign last_o = (idx == 3'd7);

endmodule

// File: rtl/scan_ctrl.sv
// Scan-chain controller: byte-streamed SHIFT, RUN clock bursts, DUT reset.
// Ports: cmd_* command handshake, in_*/out_* byte streams, busy_o/done_o
// status, dut_* scan pins. Optional checksum byte under SCAN_CKSUM_EN.
`timescale 1ns/1ps
module scan_ctrl
  import scan_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [CNT_W-1:0] cmd_arg_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [7:0]       in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [7:0]       out_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             dut_clk_o,
  output logic             dut_rstn_o,
  output logic             dut_se_o,
  output logic             dut_tm_o,
  output logic             dut_si_o,
  input  logic             dut_so_i
);

  localparam int BW = $clog2(NREGS + 1);
  localparam int DW = $clog2(DRST_LEN);
  localparam logic [BW-1:0] LAST = BW'(NREGS - 1);
  localparam logic [BW-1:0] ALL  = BW'(NREGS);
  localparam logic [DW-1:0] DEND = DW'(DRST_LEN - 1);

  state_e           state_q, state_n;
  logic [BW-1:0]    bit_q;
  logic [CNT_W-1:0] run_q;
  logic [DW-1:0]    drst_q;
  logic             clk_q, rst_q, se_q;
  logic             cmd_fire, all_bits, cks_more;
  logic             last_b;
  logic [7:0]       byte_q;

  // rst_q is low only during reset and DRST, so it also masks
  // cmd_ready_o while rstn is asserted
  assign cmd_ready_o = (state_q == S_IDLE) & rst_q;
  assign cmd_fire    = cmd_valid_i & cmd_ready_o;
  assign in_ready_o  = (state_q == S_FETCH);
  assign out_valid_o = (state_q == S_PUSH);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign all_bits    = (bit_q == ALL);
  assign dut_clk_o   = clk_q;
  assign dut_rstn_o  = rst_q;
  assign dut_se_o    = se_q;
  assign dut_tm_o    = se_q;

  scan_byte_serdes u_serdes (
    .clk    (clk),
    .rstn   (rstn),
    .ld_i   (in_ready_o & in_valid_i),
    .din_i  (in_data_i),
    .adv_i  (state_q == S_HI),
    .smp_i  (state_q == S_LO),
    .clr_i  (out_valid_o & out_ready_i),
    .so_i   (dut_so_i),
    .si_o   (dut_si_o),
    .byte_o (byte_q),
    .last_o (last_b)
  );

`ifdef SCAN_CKSUM_EN
  logic [7:0] cks_q;
  logic       cks_ph_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cks_q    <= '0;
      cks_ph_q <= 1'b0;
    end else if (state_q == S_IDLE) begin
      cks_q    <= '0;
      cks_ph_q <= 1'b0;
    end else if (out_valid_o && out_ready_i) begin
      if (!cks_ph_q)
        cks_q <= cks_q ^ byte_q;
      if (all_bits)
        cks_ph_q <= 1'b1;
    end
  end

  assign cks_more   = ~cks_ph_q;
  assign out_data_o = cks_ph_q ? cks_q : byte_q;
`else
  assign cks_more   = 1'b0;
  assign out_data_o = byte_q;
`endif

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          unique case (cmd_op_i)
            OP_SHIFT: state_n = S_FETCH;
            OP_RUN:   state_n = (cmd_arg_i == '0) ? S_DONE : S_RUN_LO;
            OP_DRST:  state_n = S_DRST;
            default:  state_n = S_DONE;
          endcase
        end
      end
      S_FETCH:  if (in_valid_i) state_n = S_LO;
      S_LO:     state_n = S_HI;
      S_HI:     state_n = (bit_q == LAST || last_b) ? S_PUSH : S_LO;
      S_PUSH: begin
        if (out_ready_i) begin
          if (!all_bits)     state_n = S_FETCH;
          else if (cks_more) state_n = S_PUSH;
          else               state_n = S_DONE;
        end
      end
      S_RUN_LO: state_n = S_RUN_HI;
      S_RUN_HI: state_n = (run_q == CNT_W'(1)) ? S_DONE : S_RUN_LO;
      S_DRST:   if (drst_q == DEND) state_n = S_DONE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      run_q   <= '0;
      drst_q  <= '0;
      clk_q   <= 1'b0;
      rst_q   <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      // pins follow the next state so they change with the state register
      clk_q   <= (state_n == S_HI) | (state_n == S_RUN_HI);
      rst_q   <= (state_n != S_DRST);
      se_q    <= (state_n == S_FETCH) | (state_n == S_LO) |
                 (state_n == S_HI) | (state_n == S_PUSH);
      if (state_q == S_IDLE) begin
        bit_q  <= '0;
        run_q  <= cmd_arg_i;
        drst_q <= '0;
      end
      if (state_q == S_HI)     bit_q  <= bit_q + 1'b1;
      if (state_q == S_RUN_HI) run_q  <= run_q - 1'b1;
      if (state_q == S_DRST)   drst_q <= drst_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_scan_ctrl.sv
// Self-checking bench for scan_ctrl with 16-bit and 19-bit chains.
// Looped DUT shift-register models stand in for the scanned device.
`timescale 1ns/1ps
module tb_scan_ctrl;
  import scan_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [15:0] cmd_arg;
  logic       in_valid, in_ready;
  logic [7:0] in_data;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic       busy, done, dclk, drstn, se, tm, si, so;

  scan_ctrl #(.NREGS(16), .CNT_W(16)) u_dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_arg_i(cmd_arg),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data),
    .busy_o(busy), .done_o(done),
    .dut_clk_o(dclk), .dut_rstn_o(drstn), .dut_se_o(se),
    .dut_tm_o(tm), .dut_si_o(si), .dut_so_i(so)
  );

  logic       cmd_valid_b, cmd_ready_b;
  logic [1:0] cmd_op_b;
  logic [15:0] cmd_arg_b;
  logic       in_valid_b, in_ready_b;
  logic [7:0] in_data_b;
  logic       out_valid_b, out_ready_b;
  logic [7:0] out_data_b;
  logic       busy_b, done_b, dclk_b, drstn_b, se_b, tm_b, si_b, so_b;

  scan_ctrl #(.NREGS(19), .CNT_W(16)) u_dut19 (
    .clk(clk), .rstn(rstn),
    .cmd_valid_i(cmd_valid_b), .cmd_ready_o(cmd_ready_b),
    .cmd_op_i(cmd_op_b), .cmd_arg_i(cmd_arg_b),
    .in_valid_i(in_valid_b), .in_ready_o(in_ready_b),
    .in_data_i(in_data_b),
    .out_valid_o(out_valid_b), .out_ready_i(out_ready_b),
    .out_data_o(out_data_b),
    .busy_o(busy_b), .done_o(done_b),
    .dut_clk_o(dclk_b), .dut_rstn_o(drstn_b), .dut_se_o(se_b),
    .dut_tm_o(tm_b), .dut_si_o(si_b), .dut_so_i(so_b)
  );

  // scanned-device models: right shift, scan-in enters at the MSB
  logic [15:0] dmod, mval;
  logic        mload = 1'b0;
  always @(posedge dclk or posedge mload)
    if (mload) dmod <= mval;
    else       dmod <= {si, dmod[15:1]};
  assign so = dmod[0];

  logic [18:0] dm19, mval19;
  logic        mload19 = 1'b0;
  always @(posedge dclk_b or posedge mload19)
    if (mload19) dm19 <= mval19;
    else         dm19 <= {si_b, dm19[18:1]};
  assign so_b = dm19[0];

  int rises = 0;
  int rises_nse = 0;
  always @(posedge dclk) begin
    rises = rises + 1;
    if (se === 1'b0) rises_nse = rises_nse + 1;
  end

  logic [7:0] in_q[$];
  logic [7:0] out_q[$];
  int n_in;
  bit got_done;
  int stall_bad;

  task automatic preload(input logic [15:0] p);
    mval = p;
    mload = 1'b1;
    #1 mload = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] arg);
    int w;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errs++;
      $display("FAIL cmd_accept op=%0d ready=%b exp=1", op, cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_arg = arg;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_shift(input int hold);
    int cyc;
    bit held;
    logic [7:0] d0;
    out_q.delete();
    n_in = 0;
    got_done = 0;
    stall_bad = 0;
    held = 0;
    cyc = 0;
    issue(OP_SHIFT, 16'd0);
    while (cyc < 3000) begin
      if (done) begin
        got_done = 1;
        break;
      end
      in_valid = (n_in < in_q.size()) && ($urandom % 4 != 0);
      in_data = in_valid ? in_q[n_in] : 8'h00;
      out_ready = ($urandom % 4 != 0);
      if (out_valid && !held && hold > 0) begin
        held = 1;
        d0 = out_data;
        for (int k = 0; k < hold; k++) begin
          out_ready = 1'b0;
          in_valid = 1'b0;
          @(negedge clk);
          if (dclk !== 1'b0 || out_data !== d0 || out_valid !== 1'b1)
            stall_bad++;
        end
        out_ready = 1'b1;
      end
      if (in_valid && in_ready) n_in++;
      if (out_valid && out_ready) out_q.push_back(out_data);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_shift(input string nm, input logic [15:0] pat,
                            input logic [7:0] b0, input logic [7:0] b1,
                            input int hold);
    logic [7:0] exp[$];
    int bad;
    preload(pat);
    in_q = '{b0, b1};
    rises = 0;
    rises_nse = 0;
    run_shift(hold);
    exp = '{pat[7:0], pat[15:8]};
`ifdef SCAN_CKSUM_EN
    exp.push_back(pat[7:0] ^ pat[15:8]);
`endif
    checks++;
    if (!got_done) begin
      errs++;
      $display("FAIL %s done got=0 exp=1", nm);
    end
    checks++;
    bad = 0;
    if (out_q.size() != exp.size()) bad = 1;
    else foreach (exp[i]) if (out_q[i] !== exp[i]) bad++;
    if (bad != 0) begin
      errs++;
      $display("FAIL %s out_bytes got=%p exp=%p", nm, out_q, exp);
    end
    checks++;
    if (dmod !== {b1, b0}) begin
      errs++;
      $display("FAIL %s dut_state got=%h exp=%h", nm, dmod, {b1, b0});
    end
    checks++;
    if (rises != 16 || rises_nse != 0) begin
      errs++;
      $display("FAIL %s clk_rises got=%0d/%0d exp=16/0",
               nm, rises, rises_nse);
    end
    checks++;
    if (n_in != 2) begin
      errs++;
      $display("FAIL %s in_bytes got=%0d exp=2", nm, n_in);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || se !== 1'b0 || tm !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL %s after got=%b%b%b%b exp=0000",
               nm, done, se, tm, busy);
    end
    if (hold > 0) begin
      checks++;
      if (stall_bad != 0) begin
        errs++;
        $display("FAIL %s stall bad_cycles=%0d exp=0", nm, stall_bad);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({dclk, drstn, se, tm, si, out_valid, out_data,
         in_ready, busy, done, cmd_ready} !== 18'd0) begin
      errs++;
      $display("FAIL reset_outputs got=%b exp=0",
               {dclk, drstn, se, tm, si, out_valid, out_data,
                in_ready, busy, done, cmd_ready});
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (drstn !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_release got=%b%b%b exp=110",
               drstn, cmd_ready, busy);
    end
  endtask

  task automatic test_run();
    int args[$];
    args = '{5, 0, int'($urandom_range(1, 20)),
             int'($urandom_range(1, 20)), int'($urandom_range(1, 40))};
    foreach (args[i]) begin
      int cyc;
      bit dn;
      rises = 0;
      rises_nse = 0;
      cyc = 0;
      issue(OP_RUN, 16'(args[i]));
      while (!done && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      dn = done;
      @(negedge clk);
      checks++;
      if (!dn || done !== 1'b0) begin
        errs++;
        $display("FAIL run_done arg=%0d got=%b,%b exp=1,0",
                 args[i], dn, done);
      end
      checks++;
      if (rises != args[i] || rises_nse != args[i]) begin
        errs++;
        $display("FAIL run_rises arg=%0d got=%0d/%0d exp=%0d",
                 args[i], rises, rises_nse, args[i]);
      end
    end
  endtask

  task automatic test_dutrst();
    int lo, cyc;
    lo = 0;
    cyc = 0;
    rises = 0;
    issue(OP_DRST, 16'd0);
    while (!done && cyc < 50) begin
      if (drstn === 1'b0) lo++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (done !== 1'b1 || lo != 4 || rises != 0) begin
      errs++;
      $display("FAIL dutrst got=done%b low%0d rises%0d exp=done1 low4 rises0",
               done, lo, rises);
    end
    @(negedge clk);
    checks++;
    if (drstn !== 1'b1 || done !== 1'b0) begin
      errs++;
      $display("FAIL dutrst_end got=%b%b exp=10", drstn, done);
    end
    issue(OP_NOP, 16'd0);
    checks++;
    if (done !== 1'b1 || rises != 0) begin
      errs++;
      $display("FAIL nop_done got=%b rises=%0d exp=1 rises=0", done, rises);
    end
  endtask

  task automatic test_partial_byte();
    logic [7:0] arr[3];
    logic [7:0] got[$];
    logic [7:0] exp[$];
    int n, cyc, bad;
    foreach (arr[i]) arr[i] = 8'($urandom);
    mval19 = 19'($urandom);
    mload19 = 1'b1;
    #1 mload19 = 1'b0;
    exp = '{mval19[7:0], mval19[15:8], {5'd0, mval19[18:16]}};
`ifdef SCAN_CKSUM_EN
    exp.push_back(exp[0] ^ exp[1] ^ exp[2]);
`endif
    n = 0;
    cyc = 0;
    @(negedge clk);
    cmd_valid_b = 1'b1;
    cmd_op_b = OP_SHIFT;
    @(negedge clk);
    cmd_valid_b = 1'b0;
    while (!done_b && cyc < 2000) begin
      in_valid_b = (n < 3);
      in_data_b = (n < 3) ? arr[n] : 8'h00;
      out_ready_b = 1'b1;
      if (in_valid_b && in_ready_b) n++;
      if (out_valid_b) got.push_back(out_data_b);
      @(negedge clk);
      cyc++;
    end
    in_valid_b = 1'b0;
    out_ready_b = 1'b0;
    checks++;
    if (done_b !== 1'b1 || n != 3) begin
      errs++;
      $display("FAIL p19_inputs got=done%b n%0d exp=done1 n3", done_b, n);
    end
    checks++;
    bad = 0;
    if (got.size() != exp.size()) bad = 1;
    else foreach (exp[i]) if (got[i] !== exp[i]) bad++;
    if (bad != 0) begin
      errs++;
      $display("FAIL p19_out_bytes got=%p exp=%p", got, exp);
    end
    checks++;
    if (got.size() < 3 || got[2][7:3] !== 5'd0) begin
      errs++;
      $display("FAIL p19_msbs got=%p exp=byte2[7:3]=0", got);
    end
    checks++;
    if (dm19 !== {arr[2][2:0], arr[1], arr[0]}) begin
      errs++;
      $display("FAIL p19_dut_state got=%h exp=%h",
               dm19, {arr[2][2:0], arr[1], arr[0]});
    end
  endtask

  task automatic test_reset_mid_shift();
    int cyc;
    bit dn;
    cyc = 0;
    dn = 0;
    preload(16'($urandom));
    in_q = '{8'($urandom), 8'($urandom)};
    rises = 0;
    issue(OP_SHIFT, 16'd0);
    while (rises < 7 && cyc < 200) begin
      if (done) dn = 1;
      in_valid = 1'b1;
      in_data = in_q[0];
      out_ready = 1'b1;
      @(negedge clk);
      cyc++;
    end
    rstn = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++;
    if ({dclk, drstn, se, tm, si, out_valid, out_data,
         in_ready, busy, done, cmd_ready} !== 18'd0 || rises != 7) begin
      errs++;
      $display("FAIL midrst_outputs got=%b rises=%0d exp=0 rises=7",
               {dclk, drstn, se, tm, si, out_valid, out_data,
                in_ready, busy, done, cmd_ready}, rises);
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) dn = 1;
    end
    checks++;
    if (dn || drstn !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL midrst_abort got=done%b rstn%b busy%b exp=done0 rstn1 busy0",
               dn, drstn, busy);
    end
    test_shift("post_reset", 16'($urandom), 8'($urandom), 8'($urandom), 0);
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = 16'd0;
    in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
    cmd_valid_b = 1'b0; cmd_op_b = 2'd0; cmd_arg_b = 16'd0;
    in_valid_b = 1'b0; in_data_b = 8'd0; out_ready_b = 1'b0;
    mval = 16'd0; mval19 = 19'd0;
    test_reset();
    test_shift("fixed", 16'h1234, 8'hA5, 8'h3C, 0);
    test_shift("stall", 16'($urandom), 8'($urandom), 8'($urandom), 10);
    for (int r = 0; r < 3; r++)
      test_shift("random", 16'($urandom), 8'($urandom), 8'($urandom), 0);
    test_run();
    test_dutrst();
    test_partial_byte();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
